// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO block: word address, select,
// active-low write strobe, write data and registered read data.
interface avalon_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_irq.sv
// avalon_pio_irq: Avalon-MM general-purpose I/O port with per-bit direction,
// atomic set/clear of output bits, synchronised inputs, per-bit edge capture
// and a maskable, registered level interrupt. Fixed 1-cycle read latency.
module avalon_pio_irq #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  avalon_pio_irq_if.slave  bus,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  // Word addresses of the register map; 6 and 7 are unused.
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5
  } reg_addr_e;

  // The arm counter must be able to hold SYNC_STAGES+1.
  localparam int             ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic             write_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_word;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  // Bits of writedata above WIDTH carry no meaning for this port.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign write_en = bus.chipselect && !bus.write_n;
  assign wdata    = bus.writedata[WIDTH-1:0];
  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt == ARM_DONE);
  assign pio_out  = data_out;
  assign pio_oe   = dir;

  // Input synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the chain is ordinary flops rather than a RAM, so every stage
      // gets reset; otherwise sync_in would be X right after reset.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_in <= '0;
    end else begin
      // NOTE: non-blocking updates make each stage take the previous stage's
      // old value, which is what turns this loop into a shift chain.
      sync_q[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_in <= sync_q[SYNC_STAGES-1];
    end
  end

  // Arm counter: holds off edge capture while the chain fills after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Edge detection and capture set/clear terms.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, starting
    // with a default, so no latch is inferred.
    edge_hit = '0;
    if (EDGE_TYPE == 0) begin
      edge_hit = sync_in & ~prev_in;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~sync_in & prev_in;
    end else begin
      edge_hit = sync_in ^ prev_in;
    end
    cap_set = armed ? (edge_hit & ~dir) : '0;
    cap_clr = (write_en && (bus.address == REG_EDGE)) ? wdata : '0;
  end

  // Edge capture register: write-1-to-clear, and a new edge wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
    end
  end

  // Software-writable registers: output data, direction and interrupt mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irq_mask <= '0;
    end else if (write_en) begin
      case (bus.address)
        REG_DATA:   data_out <= wdata;
        REG_DIR:    dir      <= wdata;
        REG_MASK:   irq_mask <= wdata;
        REG_OUTSET: data_out <= data_out | wdata;
        REG_OUTCLR: data_out <= data_out & ~wdata;
        default:    ;
      endcase
    end
  end

  // Read mux: DATA shows output bits from data_out and input bits from pins.
  always_comb begin
    rd_word = '0;
    case (bus.address)
      REG_DATA: rd_word = (dir & data_out) | (~dir & sync_in);
      REG_DIR:  rd_word = dir;
      REG_MASK: rd_word = irq_mask;
      REG_EDGE: rd_word = edge_cap;
      default:  rd_word = '0;
    endcase
  end

  // Registered read data and interrupt, both updated every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= 32'(rd_word);
      irq          <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Testbench for avalon_pio_irq: two instances (rising-edge, 2-stage sync with
// non-zero reset values; any-edge, 3-stage sync) checked by directed scenario
// tasks and a randomized run against a cycle-level behavioural model.
module tb_avalon_pio_irq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pin0, pin2;
  logic [W-1:0] pout0, pout2, poe0, poe2;
  logic         irq0, irq2;
  int           checks = 0;
  int           errors = 0;

  avalon_pio_irq_if bus0();
  avalon_pio_irq_if bus2();

  avalon_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0),
    .RESET_OUT(8'h05), .RESET_DIR(8'h0F)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .pio_in(pin0), .pio_out(pout0), .pio_oe(poe0), .irq(irq0)
  );

  avalon_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(3), .EDGE_TYPE(2),
    .RESET_OUT(8'h00), .RESET_DIR(8'h00)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .pio_in(pin2), .pio_out(pout2), .pio_oe(poe2), .irq(irq2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0 = dut0, 1 = dut2) ----------
  logic [W-1:0] m_data [2];
  logic [W-1:0] m_dir  [2];
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_cap  [2];
  logic         m_irq  [2];
  logic [31:0]  m_rd   [2];
  logic [W-1:0] hist   [2][8];   // hist[s][j] = pin value sampled j edges ago
  int           n_edges [2];

  function automatic int stages_of(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic int etype_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    m_data[0] = 8'h05; m_dir[0] = 8'h0F;
    m_data[1] = 8'h00; m_dir[1] = 8'h00;
    for (int s = 0; s < 2; s++) begin
      m_mask[s] = '0; m_cap[s] = '0; m_irq[s] = 1'b0; m_rd[s] = '0;
      n_edges[s] = 0;
      for (int j = 0; j < 8; j++) hist[s][j] = '0;
    end
  endtask

  task automatic model_step(input int s);
    logic         cs, wn, wen;
    logic [2:0]   a;
    logic [W-1:0] wd, pin, sy, pv, ev, clr, v;
    int           st;
    cs  = (s == 0) ? bus0.chipselect : bus2.chipselect;
    wn  = (s == 0) ? bus0.write_n    : bus2.write_n;
    a   = (s == 0) ? bus0.address    : bus2.address;
    wd  = (s == 0) ? bus0.writedata[W-1:0] : bus2.writedata[W-1:0];
    pin = (s == 0) ? pin0 : pin2;
    wen = cs && !wn;
    st  = stages_of(s);
    // Pin value seen by software is the pin delayed by the synchroniser.
    sy  = hist[s][st-1];
    pv  = hist[s][st];
    case (etype_of(s))
      0:       ev = sy & ~pv;
      1:       ev = ~sy & pv;
      default: ev = sy ^ pv;
    endcase
    if (n_edges[s] < st + 1) ev = '0;
    ev &= ~m_dir[s];
    // Read data reflects register state before this edge.
    v = '0;
    case (a)
      3'd0: for (int b = 0; b < W; b++) v[b] = m_dir[s][b] ? m_data[s][b] : sy[b];
      3'd1: v = m_dir[s];
      3'd2: v = m_mask[s];
      3'd3: v = m_cap[s];
      default: v = '0;
    endcase
    m_rd[s]  = {24'h0, v};
    m_irq[s] = |(m_cap[s] & m_mask[s]);
    clr      = (wen && a == 3'd3) ? wd : '0;
    m_cap[s] = (m_cap[s] & ~clr) | ev;
    if (wen) begin
      case (a)
        3'd0: m_data[s] = wd;
        3'd1: m_dir[s]  = wd;
        3'd2: m_mask[s] = wd;
        3'd4: m_data[s] = m_data[s] | wd;
        3'd5: m_data[s] = m_data[s] & ~wd;
        default: ;
      endcase
    end
    for (int j = 7; j > 0; j--) hist[s][j] = hist[s][j-1];
    hist[s][0] = pin;
    if (n_edges[s] < 1000) n_edges[s]++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- bus helpers (no checking) -----------------------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int s, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = d;
    end else begin
      bus2.chipselect = cs; bus2.write_n = wn; bus2.address = a; bus2.writedata = d;
    end
  endtask

  task automatic bus_write(input int s, input logic [2:0] a, input logic [31:0] d);
    drive(s, 1'b1, 1'b0, a, d);
    step();
    drive(s, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic bus_read(input int s, input logic [2:0] a, output logic [31:0] v);
    drive(s, 1'b1, 1'b1, a, 32'h0);
    step();
    v = (s == 0) ? bus0.readdata : bus2.readdata;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    pin0 = 8'hFF; pin2 = 8'h00;
    drive(0, 1'b0, 1'b1, 3'd0, 32'h0);
    drive(1, 1'b0, 1'b1, 3'd0, 32'h0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pout0 !== 8'h05) begin errors++; $display("FAIL reset_pio_out got %h exp 05", pout0); end
    checks++; if (poe0 !== 8'h0F) begin errors++; $display("FAIL reset_pio_oe got %h exp 0f", poe0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq0); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", bus0.readdata); end
    checks++; if (pout2 !== 8'h00 || poe2 !== 8'h00) begin errors++; $display("FAIL reset_dut2 got out %h oe %h exp 00 00", pout2, poe2); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    repeat (10) step();
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL arm_edge_capture got %h exp 0", bus0.readdata); end
    checks++; if (bus0.readdata !== m_rd[0]) begin errors++; $display("FAIL arm_model got %h exp %h", bus0.readdata, m_rd[0]); end
  endtask

  task automatic test_data_dir();
    logic [31:0] v;
    pin0 = 8'h30;
    bus_write(0, 3'd1, 32'h0000_000F);
    bus_write(0, 3'd0, 32'hDEAD_BEA5);
    bus_write(0, 3'd4, 32'h0000_0010);
    bus_write(0, 3'd5, 32'h0000_0001);
    checks++; if (pout0 !== 8'hB4) begin errors++; $display("FAIL set_clear_out got %h exp b4", pout0); end
    checks++; if (poe0 !== 8'h0F) begin errors++; $display("FAIL dir_oe got %h exp 0f", poe0); end
    bus_read(0, 3'd0, v);
    checks++; if (v !== 32'h34) begin errors++; $display("FAIL data_read_mix got %h exp 34", v); end
    bus_read(0, 3'd4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL outset_read got %h exp 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    drive(0, 1'b1, 1'b0, 3'd4, 32'h0000_00C0);
    step();
    drive(0, 1'b1, 1'b0, 3'd5, 32'h0000_0004);
    step();
    drive(0, 1'b1, 1'b1, 3'd0, 32'h0);
    checks++; if (pout0 !== 8'hF0) begin errors++; $display("FAIL back_to_back_out got %h exp f0", pout0); end
    bus_read(0, 3'd0, v);
    checks++; if (v !== 32'h30) begin errors++; $display("FAIL back_to_back_read got %h exp 30", v); end
  endtask

  task automatic test_edge_irq();
    bus_write(0, 3'd1, 32'h0);
    pin0 = 8'h00;
    repeat (4) step();
    bus_write(0, 3'd3, 32'hFF);
    bus_write(0, 3'd2, 32'h80);
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    pin0 = 8'h80;
    step(); step(); step();               // edges N, N+1, N+2
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq0); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL cap_early got %h exp 0", bus0.readdata); end
    step();                               // edge N+3
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq0); end
    checks++; if (bus0.readdata !== 32'h80) begin errors++; $display("FAIL cap_rise got %h exp 80", bus0.readdata); end
    drive(0, 1'b1, 1'b0, 3'd3, 32'h80);
    step();                               // clear edge W
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_at_clear got %b exp 1", irq0); end
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    step();                               // W+1
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_after_clear got %b exp 0", irq0); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL cap_after_clear got %h exp 0", bus0.readdata); end
  endtask

  task automatic test_w1c_collision();
    bus_write(0, 3'd2, 32'h88);
    pin0 = 8'h88;
    repeat (4) step();
    pin0 = 8'h80;
    repeat (3) step();
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    pin0 = 8'h88;
    step(); step();                       // edges N, N+1
    drive(0, 1'b1, 1'b0, 3'd3, 32'h08);
    step();                               // N+2: clear and new edge together
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL collision_irq_hold got %b exp 1", irq0); end
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    step();
    checks++; if (bus0.readdata !== 32'h08) begin errors++; $display("FAIL collision_cap got %h exp 08", bus0.readdata); end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL collision_irq got %b exp 1", irq0); end
  endtask

  task automatic test_mask_dir();
    logic [31:0] v;
    drive(0, 1'b1, 1'b0, 3'd2, 32'h0);
    step();
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL mask_old_irq got %b exp 1", irq0); end
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    step();
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL mask_clear_irq got %b exp 0", irq0); end
    checks++; if (bus0.readdata !== 32'h08) begin errors++; $display("FAIL mask_cap_kept got %h exp 08", bus0.readdata); end
    bus_write(0, 3'd1, 32'h08);
    bus_read(0, 3'd3, v);
    checks++; if (v !== 32'h08) begin errors++; $display("FAIL dir_cap_kept got %h exp 08", v); end
    bus_write(0, 3'd3, 32'hFF);
    bus_write(0, 3'd1, 32'h00);
    bus_read(0, 3'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL cap_cleared got %h exp 0", v); end
  endtask

  task automatic test_edge_any();
    logic [31:0] v;
    bus_write(1, 3'd4, 32'hFF);
    checks++; if (pout2 !== 8'hFF) begin errors++; $display("FAIL outset_dut2 got %h exp ff", pout2); end
    bus_write(1, 3'd2, 32'h01);
    drive(1, 1'b1, 1'b1, 3'd3, 32'h0);
    pin2 = 8'h01;
    repeat (4) step();                    // edges N..N+3
    pin2 = 8'h00;
    drive(1, 1'b1, 1'b0, 3'd3, 32'h01);
    step();                               // N+4
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq_rise got %b exp 1", irq2); end
    drive(1, 1'b1, 1'b1, 3'd3, 32'h0);
    step();                               // N+5
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_irq_cleared got %b exp 0", irq2); end
    step(); step();                       // N+6, N+7
    checks++; if (irq2 !== 1'b0 || bus2.readdata !== 32'h0) begin errors++; $display("FAIL any_before_fall got irq %b rd %h exp 0 0", irq2, bus2.readdata); end
    step();                               // N+8
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq_fall got %b exp 1", irq2); end
    checks++; if (bus2.readdata !== 32'h01) begin errors++; $display("FAIL any_cap_fall got %h exp 01", bus2.readdata); end
    for (int a = 4; a < 8; a++) begin
      bus_read(1, 3'(a), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read_dut2 addr %0d got %h exp 0", a, v); end
      bus_read(0, 3'(a), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read_dut0 addr %0d got %h exp 0", a, v); end
    end
    bus_write(1, 3'd3, 32'hFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pin0 = pin0 ^ 8'($urandom);
      if ($urandom_range(0, 3) == 0) pin2 = pin2 ^ 8'($urandom);
      drive(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            3'($urandom_range(0, 7)), $urandom);
      drive(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            3'($urandom_range(0, 7)), $urandom);
      step();
      checks++; if (bus0.readdata !== m_rd[0]) begin errors++; $display("FAIL rand_rd0 cyc %0d got %h exp %h", i, bus0.readdata, m_rd[0]); end
      checks++; if (pout0 !== m_data[0] || poe0 !== m_dir[0]) begin errors++; $display("FAIL rand_pins0 cyc %0d got %h/%h exp %h/%h", i, pout0, poe0, m_data[0], m_dir[0]); end
      checks++; if (irq0 !== m_irq[0]) begin errors++; $display("FAIL rand_irq0 cyc %0d got %b exp %b", i, irq0, m_irq[0]); end
      checks++; if (bus2.readdata !== m_rd[1]) begin errors++; $display("FAIL rand_rd2 cyc %0d got %h exp %h", i, bus2.readdata, m_rd[1]); end
      checks++; if (pout2 !== m_data[1] || poe2 !== m_dir[1]) begin errors++; $display("FAIL rand_pins2 cyc %0d got %h/%h exp %h/%h", i, pout2, poe2, m_data[1], m_dir[1]); end
      checks++; if (irq2 !== m_irq[1]) begin errors++; $display("FAIL rand_irq2 cyc %0d got %b exp %b", i, irq2, m_irq[1]); end
    end
    drive(0, 1'b0, 1'b1, 3'd0, 32'h0);
    drive(1, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic test_reset_async();
    logic [31:0] v;
    bus_write(0, 3'd1, 32'h0);
    bus_write(0, 3'd2, 32'hFF);
    pin0 = 8'h00;
    repeat (4) step();
    pin0 = 8'hFF;
    repeat (5) step();
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pending_irq got %b exp 1", irq0); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pout0 !== 8'h05 || poe0 !== 8'h0F) begin errors++; $display("FAIL async_pins got %h/%h exp 05/0f", pout0, poe0); end
    checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL async_irq got %b/%b exp 0/0", irq0, irq2); end
    checks++; if (bus0.readdata !== 32'h0 || bus2.readdata !== 32'h0) begin errors++; $display("FAIL async_readdata got %h/%h exp 0/0", bus0.readdata, bus2.readdata); end
    checks++; if (pout2 !== 8'h00 || poe2 !== 8'h00) begin errors++; $display("FAIL async_dut2 got %h/%h exp 00/00", pout2, poe2); end
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b1, 3'd3, 32'h0);
    repeat (6) step();
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL cap_discarded got %h exp 0", bus0.readdata); end
    bus_read(0, 3'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mask_after_reset got %h exp 0", v); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_data_dir();
    test_back_to_back();
    test_edge_irq();
    test_w1c_collision();
    test_mask_dir();
    test_edge_any();
    test_random();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
